csr_ctrl: RTL and testbench

CSR/trap sequencer between the execute stage and the machine-mode CSR file. It accepts one CSR instruction, `ecall`, or `mret` per handshake. For each request it drives the CSR file's address, write-enable, write-data, `ecall` and `mret` strobes, then returns the old CSR value for `rd` writeback and a PC redirect target to the pipeline. It owns the read-modify-write arithmetic for the Zicsr ops, so the CSR file stays a plain storage and mux block.

---
 rtl/csr_ctrl.sv | 161 ++++++++++++++++
 tb/tb_csr_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/csr_ctrl.sv
// CSR/trap sequencer between execute and the machine-mode CSR file.
// Owns the Zicsr read-modify-write so the CSR file is plain storage.
module csr_ctrl #(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [2:0]        op_i,
  input  logic              is_ecall_i,
  input  logic              is_mret_i,
  input  logic [CSR_AW-1:0] csr_addr_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [4:0]        zimm_i,
  input  logic              rs1_zero_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   csr_rdata_i,
  output logic [CSR_AW-1:0] csr_addr_o,
  output logic              csr_wen_o,
  output logic [XLEN-1:0]   csr_wdata_o,
  output logic              ecall_o,
  output logic              mret_o,
  output logic [XLEN-1:0]   mepc_o,
  output logic [XLEN-1:0]   mcause_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [XLEN-1:0]   rd_data_o,
  output logic              redirect_o,
  output logic [XLEN-1:0]   redirect_pc_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WRITE, S_TRAP, S_RET, S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_redirect;
  logic [2:0]        r_op;
  logic [CSR_AW-1:0] r_addr;
  logic [XLEN-1:0]   r_rs1;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_old;
  logic [XLEN-1:0]   r_rpc;
  logic [4:0]        r_zimm;
  logic              r_rs1_zero;
  logic              w_accept;
  logic [XLEN-1:0]   w_src;

  function automatic logic [XLEN-1:0] rmw_f(input logic [2:0] op,
                                            input logic [XLEN-1:0] old,
                                            input logic [XLEN-1:0] src);
    case (op[1:0])
      2'b01:   rmw_f = src;
      2'b10:   rmw_f = old | src;
      2'b11:   rmw_f = old & ~src;
      default: rmw_f = '0;
    endcase
  endfunction

  // Set/clear with a zero source is a pure read and must not side-effect the CSR.
  function automatic logic wen_f(input logic [2:0] op, input logic [4:0] zimm,
                                 input logic rs1_zero);
    if (op[1:0] == 2'b00)
      wen_f = 1'b0;
    else if (op[1] && !op[2])
      wen_f = !rs1_zero;
    else if (op[1] && op[2])
      wen_f = (zimm != 5'd0);
    else
      wen_f = 1'b1;
  endfunction

  assign w_accept = valid_i & ready_o;
  assign w_src    = r_op[2] ? {{(XLEN-5){1'b0}}, r_zimm} : r_rs1;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= S_IDLE;
      r_redirect <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept)
        r_redirect <= is_ecall_i | is_mret_i;
    end
  end

  // Datapath latches: only observed through state-gated outputs, so no reset.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_op       <= op_i;
      r_addr     <= csr_addr_i;
      r_rs1      <= rs1_data_i;
      r_zimm     <= zimm_i;
      r_pc       <= pc_i;
      r_rs1_zero <= rs1_zero_i;
    end
    if (r_state == S_READ)
      r_old <= csr_rdata_i;
    if (r_state == S_TRAP || r_state == S_RET)
      r_rpc <= csr_rdata_i;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (valid_i) begin
          if (is_ecall_i)     w_next = S_TRAP;
          else if (is_mret_i) w_next = S_RET;
          else                w_next = S_READ;
        end
      end
      S_READ:  w_next = S_WRITE;
      S_WRITE: w_next = S_RESP;
      S_TRAP:  w_next = S_RESP;
      S_RET:   w_next = S_RESP;
      S_RESP:  if (ready_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready_o       = (r_state == S_IDLE);
    csr_addr_o    = '0;
    csr_wen_o     = 1'b0;
    csr_wdata_o   = '0;
    ecall_o       = 1'b0;
    mret_o        = 1'b0;
    mepc_o        = '0;
    mcause_o      = '0;
    valid_o       = 1'b0;
    rd_data_o     = '0;
    redirect_o    = 1'b0;
    redirect_pc_o = '0;
    case (r_state)
      S_READ: csr_addr_o = r_addr;
      S_WRITE: begin
        csr_addr_o  = r_addr;
        csr_wen_o   = wen_f(r_op, r_zimm, r_rs1_zero);
        csr_wdata_o = rmw_f(r_op, r_old, w_src);
      end
      S_TRAP: begin
        ecall_o  = 1'b1;
        mepc_o   = r_pc;
        mcause_o = XLEN'(11);
      end
      S_RET: mret_o = 1'b1;
      S_RESP: begin
        valid_o       = 1'b1;
        redirect_o    = r_redirect;
        redirect_pc_o = r_redirect ? r_rpc : '0;
        rd_data_o     = r_redirect ? '0 : r_old;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_ctrl.sv
// Self-checking bench for csr_ctrl: behavioural CSR file plus a reference model
// that applies the Zicsr/trap rules directly to an array of CSR values.
module tb_csr_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i, ready_o;
  logic [2:0]  op_i;
  logic        is_ecall_i, is_mret_i;
  logic [11:0] csr_addr_i;
  logic [31:0] rs1_data_i;
  logic [4:0]  zimm_i;
  logic        rs1_zero_i;
  logic [31:0] pc_i;
  logic [31:0] csr_rdata_i;
  logic [11:0] csr_addr_o;
  logic        csr_wen_o;
  logic [31:0] csr_wdata_o;
  logic        ecall_o, mret_o;
  logic [31:0] mepc_o, mcause_o;
  logic        valid_o, ready_i;
  logic [31:0] rd_data_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;

  always #5 clk = ~clk;

  csr_ctrl #(.XLEN(32), .CSR_AW(12)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .is_ecall_i(is_ecall_i), .is_mret_i(is_mret_i),
    .csr_addr_i(csr_addr_i), .rs1_data_i(rs1_data_i), .zimm_i(zimm_i),
    .rs1_zero_i(rs1_zero_i), .pc_i(pc_i), .csr_rdata_i(csr_rdata_i),
    .csr_addr_o(csr_addr_o), .csr_wen_o(csr_wen_o), .csr_wdata_o(csr_wdata_o),
    .ecall_o(ecall_o), .mret_o(mret_o), .mepc_o(mepc_o), .mcause_o(mcause_o),
    .valid_o(valid_o), .ready_i(ready_i), .rd_data_o(rd_data_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o)
  );

  // Environment CSR file: storage, trap side effects, preload port.
  logic [31:0] mem [4096];
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [31:0] pl_data = '0;
  int          cnt_wen = 0, cnt_ecall = 0, cnt_mret = 0;

  assign csr_rdata_i = ecall_o ? mem[12'h305] : (mret_o ? mem[12'h341] : mem[csr_addr_o]);

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (csr_wen_o) mem[csr_addr_o] <= csr_wdata_o;
    if (ecall_o) begin
      mem[12'h341] <= mepc_o;
      mem[12'h342] <= mcause_o;
    end
    cnt_wen   <= cnt_wen + int'(csr_wen_o);
    cnt_ecall <= cnt_ecall + int'(ecall_o);
    cnt_mret  <= cnt_mret + int'(mret_o);
  end

  logic [31:0] ref_mem [4096];
  int n_cmp = 0, n_err = 0;
  logic [11:0] addr_tab [5] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic do_req(input bit ec, input bit mr, input logic [2:0] op,
                        input logic [11:0] addr, input logic [31:0] rs1,
                        input logic [4:0] zimm, input bit rz,
                        input logic [31:0] pc, input int bp);
    int cyc, w0, e0, m0;
    bit trap, wr;
    logic [31:0] old, src, nv, exp_rd, exp_rpc;
    trap = ec | mr;
    wr = 1'b0; nv = '0; exp_rd = '0; exp_rpc = '0;
    if (ec) exp_rpc = ref_mem[12'h305];
    else if (mr) exp_rpc = ref_mem[12'h341];
    else begin
      old = ref_mem[addr];
      exp_rd = old;
      src = op[2] ? {27'd0, zimm} : rs1;
      case (op)
        3'd1, 3'd5: begin nv = src;        wr = 1'b1; end
        3'd2:       begin nv = old | src;  wr = !rz; end
        3'd3:       begin nv = old & ~src; wr = !rz; end
        3'd6:       begin nv = old | src;  wr = (zimm != 0); end
        3'd7:       begin nv = old & ~src; wr = (zimm != 0); end
        default:    wr = 1'b0;
      endcase
    end

    @(negedge clk);
    check_val("ready_idle", ready_o, 1);
    valid_i = 1'b1; is_ecall_i = ec; is_mret_i = mr; op_i = op;
    csr_addr_i = addr; rs1_data_i = rs1; zimm_i = zimm; rs1_zero_i = rz;
    pc_i = pc; ready_i = 1'b0;
    w0 = cnt_wen; e0 = cnt_ecall; m0 = cnt_mret;
    @(posedge clk);
    #1;
    valid_i = 1'b0; is_ecall_i = 1'b0; is_mret_i = 1'b0;
    ready_i = (bp == 0);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!valid_o && cyc < 8);
    check_val("latency", cyc, trap ? 2 : 3);
    check_val("redirect", redirect_o, trap);
    check_val("redirect_pc", redirect_pc_o, exp_rpc);
    if (!mr || ec) check_val("rd_data", rd_data_o, exp_rd);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check_val("bp_valid", valid_o, 1);
      check_val("bp_ready", ready_o, 0);
      check_val("bp_rd_data", (!mr || ec) ? rd_data_o : 32'd0, exp_rd);
      check_val("bp_redirect_pc", redirect_pc_o, exp_rpc);
    end
    if (bp > 0) ready_i = 1'b1;
    @(negedge clk);
    check_val("back_idle_ready", ready_o, 1);
    check_val("back_idle_valid", valid_o, 0);
    ready_i = 1'b0;
    check_val("wen_pulses", cnt_wen - w0, int'(wr));
    check_val("ecall_pulses", cnt_ecall - e0, int'(ec));
    check_val("mret_pulses", cnt_mret - m0, int'(mr && !ec));
    if (ec) begin
      ref_mem[12'h341] = pc;
      ref_mem[12'h342] = 32'd11;
      check_val("mepc_stored", mem[12'h341], ref_mem[12'h341]);
      check_val("mcause_stored", mem[12'h342], ref_mem[12'h342]);
    end else if (!mr) begin
      if (wr) ref_mem[addr] = nv;
      check_val("csr_value", mem[addr], ref_mem[addr]);
    end
  endtask

  initial begin
    int w0;
    bit ec, mr, rz;
    logic [2:0] op;
    logic [31:0] rs1;
    rst_i = 1'b0; valid_i = 1'b0; op_i = '0; is_ecall_i = 1'b0; is_mret_i = 1'b0;
    csr_addr_i = '0; rs1_data_i = '0; zimm_i = '0; rs1_zero_i = 1'b0;
    pc_i = '0; ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_ready", ready_o, 1);
    check_val("rst_valid", valid_o, 0);
    check_val("rst_wen", csr_wen_o, 0);
    check_val("rst_addr", csr_addr_o, 0);
    check_val("rst_redirect", redirect_o, 0);
    check_val("rst_rd_data", rd_data_o, 0);
    rst_i = 1'b1;
    for (int i = 0; i < 5; i++) preload(addr_tab[i], 32'd0);

    do_req(0, 0, 3'd1, 12'h305, 32'h80000100, 5'd0, 0, 0, 4);
    preload(12'h300, 32'h1800);
    do_req(0, 0, 3'd2, 12'h300, 32'h8, 5'd0, 0, 0, 0);
    preload(12'h300, 32'h1800);
    do_req(0, 0, 3'd2, 12'h300, 32'h0, 5'd0, 1, 0, 1);
    preload(12'h341, 32'h8000000F);
    do_req(0, 0, 3'd7, 12'h341, 32'h0, 5'd3, 0, 0, 0);
    do_req(0, 0, 3'd7, 12'h341, 32'h0, 5'd0, 0, 0, 2);
    do_req(1, 0, 3'd0, 12'h000, 32'h0, 5'd0, 0, 32'h80000040, 0);
    preload(12'h341, 32'h80000044);
    do_req(0, 1, 3'd0, 12'h000, 32'h0, 5'd0, 0, 0, 4);
    do_req(1, 1, 3'd0, 12'h000, 32'h0, 5'd0, 0, 32'h80000010, 0);
    do_req(0, 0, 3'd4, 12'h300, 32'hFFFFFFFF, 5'd9, 0, 0, 0);

    // Reset asserted while the request sits in READ.
    @(negedge clk);
    w0 = cnt_wen;
    valid_i = 1'b1; op_i = 3'd1; csr_addr_i = 12'h300; rs1_data_i = 32'hDEADBEEF;
    rs1_zero_i = 1'b0;
    @(posedge clk);
    #1 valid_i = 1'b0;
    #2 rst_i = 1'b0;
    #1;
    check_val("midrst_wen", csr_wen_o, 0);
    check_val("midrst_addr", csr_addr_o, 0);
    check_val("midrst_ready", ready_o, 1);
    check_val("midrst_valid", valid_o, 0);
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    repeat (4) @(negedge clk);
    check_val("midrst_no_write", cnt_wen - w0, 0);
    check_val("midrst_csr_kept", mem[12'h300], ref_mem[12'h300]);
    do_req(0, 0, 3'd1, 12'h300, 32'h12345678, 5'd0, 0, 0, 0);

    for (int t = 0; t < 80; t++) begin
      int k;
      k  = $urandom_range(0, 19);
      ec = (k == 0) || (k == 1);
      mr = (k == 1) || (k == 2) || (k == 3);
      op = 3'($urandom_range(0, 7));
      rz = ($urandom_range(0, 3) == 0);
      rs1 = rz ? 32'd0 : $urandom;
      do_req(ec, mr, op, addr_tab[$urandom_range(0, 4)], rs1,
             ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
             rz, $urandom & 32'hFFFFFFFC, $urandom_range(0, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
